serial_frame_demux: RTL and testbench

- Parametrised successor to the fixed 2-bit-port / 4-bit-length serial receiver (main_state + datapath).
- Samples a one-bit serial line every clock and parses frames: start bit (0), PORT_W-bit port address, LEN_W-bit payload length, LEN payload bits.
- Forwards each payload bit to one of NUM_PORTS output channels, with a per-channel valid.
- Adds length-0 frames, invalid-port detection, a frame-done pulse and a busy flag.

---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/serial_frame_demux_if.sv | 43 ++++
 rtl/frame_field_counter.sv | 40 ++++
 rtl/serial_frame_demux.sv | 190 +++++++++++++++++++
 tb/tb_serial_frame_demux.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame demultiplexer.
// The PARITY state is only reachable when SERIAL_FRAME_PARITY_EN is defined.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PORT   = 3'd1,
      ST_LEN    = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4
   } state_e;

   // The field counter must cover both the port and the length field.
   function automatic int cnt_width(input int port_w, input int len_w);
      if (port_w > len_w) begin
         return port_w;
      end else begin
         return len_w;
      end
   endfunction

endpackage

// File: rtl/serial_frame_demux_if.sv
// Serial line plus demultiplexed outputs of serial_frame_demux.
// parity_err exists only when SERIAL_FRAME_PARITY_EN is defined.
interface serial_frame_demux_if #(
   parameter int PORT_W    = 2,
   parameter int NUM_PORTS = 4
);
   logic                 ser_in;
   logic [NUM_PORTS-1:0] ser_out;
   logic [NUM_PORTS-1:0] ser_out_valid;
   logic [PORT_W-1:0]    port_addr;
   logic                 busy;
   logic                 frame_done;
   logic                 port_err;
`ifdef SERIAL_FRAME_PARITY_EN
   logic                 parity_err;
`endif

   modport master (
      input  ser_in,
`ifdef SERIAL_FRAME_PARITY_EN
      output parity_err,
`endif
      output ser_out,
      output ser_out_valid,
      output port_addr,
      output busy,
      output frame_done,
      output port_err
   );

   modport slave (
      output ser_in,
`ifdef SERIAL_FRAME_PARITY_EN
      input  parity_err,
`endif
      input  ser_out,
      input  ser_out_valid,
      input  port_addr,
      input  busy,
      input  frame_done,
      input  port_err
   );
endinterface

// File: rtl/frame_field_counter.sv
// Loadable up-counter with clear and enable; tc flags cnt == tc_val.
module frame_field_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] tc_val,
   output logic             tc
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear wins over load, load over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == tc_val);
endmodule

// File: rtl/serial_frame_demux.sv
// Parses start|port|len|payload frames off a serial line and routes payload bits
// to per-port channels. Define SERIAL_FRAME_PARITY_EN for a trailing even-parity bit.
module serial_frame_demux
   import serial_frame_pkg::*;
#(
   parameter int PORT_W    = 2,
   parameter int LEN_W     = 4,
   parameter int NUM_PORTS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   serial_frame_demux_if.master   bus
);
   localparam int CNT_W = cnt_width(PORT_W, LEN_W);

   state_e               state_q, state_d;
   logic [PORT_W-1:0]    port_addr_q, port_addr_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [NUM_PORTS-1:0] ser_out_q, ser_out_d;
   logic [NUM_PORTS-1:0] valid_q, valid_d;
   logic                 frame_done_q, frame_done_d;
   logic                 port_err_q, port_err_d;
   logic [CNT_W-1:0]     tc_val_s;
   logic                 cnt_clr_s, cnt_en_s, cnt_tc_s;
   logic [LEN_W-1:0]     len_shift_s;
   logic                 port_ok_s;
`ifdef SERIAL_FRAME_PARITY_EN
   logic                 par_q, par_d;
   logic                 parity_err_q, parity_err_d;
`endif

   assign len_shift_s = LEN_W'({len_q, bus.ser_in});
   assign port_ok_s   = ({1'b0, port_addr_q} < (PORT_W + 1)'(NUM_PORTS));

   frame_field_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (cnt_clr_s),
      .en       (cnt_en_s),
      .load     (1'b0),
      .load_val ({CNT_W{1'b0}}),
      .tc_val   (tc_val_s),
      .tc       (cnt_tc_s)
   );

   // Frame parser: next state, field shifting and one-cycle output pulses.
   always_comb begin
      state_d      = state_q;
      port_addr_d  = port_addr_q;
      len_d        = len_q;
      ser_out_d    = '0;
      valid_d      = '0;
      frame_done_d = 1'b0;
      port_err_d   = 1'b0;
      cnt_clr_s    = 1'b0;
      cnt_en_s     = 1'b0;
      tc_val_s     = '0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.ser_in) begin
               state_d   = ST_PORT;
               cnt_clr_s = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
               par_d     = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PORT: begin
            port_addr_d = PORT_W'({port_addr_q, bus.ser_in});
            tc_val_s    = CNT_W'(PORT_W - 1);
`ifdef SERIAL_FRAME_PARITY_EN
            par_d       = par_q ^ bus.ser_in;
`endif
            if (cnt_tc_s) begin
               state_d   = ST_LEN;
               cnt_clr_s = 1'b1;
            end else begin
               cnt_en_s = 1'b1;
            end
         end
         ST_LEN: begin
            len_d    = len_shift_s;
            tc_val_s = CNT_W'(LEN_W - 1);
`ifdef SERIAL_FRAME_PARITY_EN
            par_d    = par_q ^ bus.ser_in;
`endif
            if (cnt_tc_s) begin
               cnt_clr_s = 1'b1;
               if (len_shift_s != '0) begin
                  state_d = ST_DATA;
               end else begin
`ifdef SERIAL_FRAME_PARITY_EN
                  state_d      = ST_PARITY;
`else
                  state_d      = ST_IDLE;
                  frame_done_d = 1'b1;
                  port_err_d   = !port_ok_s;
`endif
               end
            end else begin
               cnt_en_s = 1'b1;
            end
         end
         ST_DATA: begin
            tc_val_s = CNT_W'(len_q - LEN_W'(1));
`ifdef SERIAL_FRAME_PARITY_EN
            par_d    = par_q ^ bus.ser_in;
`endif
            // An out-of-range port matches no channel, so the bit is silently consumed.
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (port_addr_q == PORT_W'(i)) begin
                  ser_out_d[i] = bus.ser_in;
                  valid_d[i]   = 1'b1;
               end else begin
                  ser_out_d[i] = 1'b0;
                  valid_d[i]   = 1'b0;
               end
            end
            if (cnt_tc_s) begin
               cnt_clr_s = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
               state_d      = ST_PARITY;
`else
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
               port_err_d   = !port_ok_s;
`endif
            end else begin
               cnt_en_s = 1'b1;
            end
         end
         ST_PARITY: begin
            state_d = ST_IDLE;
`ifdef SERIAL_FRAME_PARITY_EN
            frame_done_d = 1'b1;
            port_err_d   = !port_ok_s;
            parity_err_d = par_q ^ bus.ser_in;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         port_addr_q  <= '0;
         len_q        <= '0;
         ser_out_q    <= '0;
         valid_q      <= '0;
         frame_done_q <= 1'b0;
         port_err_q   <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         port_addr_q  <= port_addr_d;
         len_q        <= len_d;
         ser_out_q    <= ser_out_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         port_err_q   <= port_err_d;
`ifdef SERIAL_FRAME_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.ser_out       = ser_out_q;
   assign bus.ser_out_valid = valid_q;
   assign bus.port_addr     = port_addr_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.frame_done    = frame_done_q;
   assign bus.port_err      = port_err_q;
`ifdef SERIAL_FRAME_PARITY_EN
   assign bus.parity_err    = parity_err_q;
`endif
endmodule

// File: tb/tb_serial_frame_demux.sv
// Scoreboard bench: two DUTs (4 and 3 ports) share one serial line; each
// frame pushes per-cycle expected output events that monitors pop and compare.
module tb_serial_frame_demux;
`ifdef SERIAL_FRAME_PARITY_EN
   localparam int PAR_X = 1;
`else
   localparam int PAR_X = 0;
`endif

   typedef struct {
      int         cyc;
      logic [3:0] valid;
      logic [3:0] data;
      logic       done;
      logic       perr;
      logic [1:0] addr;
      logic       parerr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ser_in = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b1;
   exp_t qa[$];
   exp_t qb[$];
   logic a_parerr, b_parerr;

   serial_frame_demux_if #(.PORT_W(2), .NUM_PORTS(4)) bus_a ();
   serial_frame_demux_if #(.PORT_W(2), .NUM_PORTS(3)) bus_b ();

   assign bus_a.ser_in = ser_in;
   assign bus_b.ser_in = ser_in;
`ifdef SERIAL_FRAME_PARITY_EN
   assign a_parerr = bus_a.parity_err;
   assign b_parerr = bus_b.parity_err;
`else
   assign a_parerr = 1'b0;
   assign b_parerr = 1'b0;
`endif

   serial_frame_demux #(.PORT_W(2), .LEN_W(4), .NUM_PORTS(4)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.master));
   serial_frame_demux #(.PORT_W(2), .LEN_W(4), .NUM_PORTS(3)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_ev(input string tag, input exp_t e, input logic [3:0] v,
                             input logic [3:0] d, input logic done, input logic perr,
                             input logic [1:0] addr, input logic parerr);
      chk({tag, "_cycle"}, cyc, e.cyc);
      chk({tag, "_outputs"}, {v, d, done, perr, addr, parerr},
          {e.valid, e.data, e.done, e.perr, e.addr, e.parerr});
   endtask

   // Monitor for the 4-port DUT.
   always @(negedge clk) begin
      if (mon_en && (bus_a.ser_out_valid != 4'd0 || bus_a.frame_done)) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_a: valid=%b done=%b, nothing expected", bus_a.ser_out_valid, bus_a.frame_done);
         end else begin
            compare_ev("a", qa.pop_front(), bus_a.ser_out_valid, bus_a.ser_out,
                       bus_a.frame_done, bus_a.port_err, bus_a.port_addr, a_parerr);
         end
      end
   end

   // Monitor for the 3-port DUT.
   always @(negedge clk) begin
      if (mon_en && (bus_b.ser_out_valid != 3'd0 || bus_b.frame_done)) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_b: valid=%b done=%b, nothing expected", bus_b.ser_out_valid, bus_b.frame_done);
         end else begin
            compare_ev("b", qb.pop_front(), {1'b0, bus_b.ser_out_valid}, {1'b0, bus_b.ser_out},
                       bus_b.frame_done, bus_b.port_err, bus_b.port_addr, b_parerr);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ser_in = 1'b1;
      end
   endtask

   // Sends one frame; payload bit m (MSB first) is pay[len-1-m].
   task automatic send_frame(input int port, input int len, input logic [14:0] pay,
                             input logic bad_par, input bit expect_it);
      logic bits[$];
      logic par;
      exp_t e;
      int   c0;
      int   np;
      bit   last;
      par = 1'b0;
      bits.push_back(1'b0);
      for (int i = 1; i >= 0; i--) bits.push_back(port[i]);
      for (int i = 3; i >= 0; i--) bits.push_back(len[i]);
      for (int i = len - 1; i >= 0; i--) bits.push_back(pay[i]);
      for (int j = 1; j < bits.size(); j++) par = par ^ bits[j];
      if (PAR_X == 1) bits.push_back(par ^ bad_par);
      @(negedge clk);
      c0 = cyc;
      if (expect_it) begin
         for (int k = 0; k < 2; k++) begin
            np = (k == 0) ? 4 : 3;
            for (int m = 0; m < len; m++) begin
               last     = (m == len - 1) && (PAR_X == 0);
               e.cyc    = c0 + 8 + m;
               e.valid  = (port < np) ? 4'(1 << port) : 4'd0;
               e.data   = pay[len - 1 - m] ? e.valid : 4'd0;
               e.done   = last;
               e.perr   = last && (port >= np);
               e.addr   = port[1:0];
               e.parerr = 1'b0;
               if (e.valid != 4'd0 || last) begin
                  if (k == 0) qa.push_back(e); else qb.push_back(e);
               end
            end
            if (len == 0 || PAR_X == 1) begin
               e.cyc    = c0 + 7 + len + PAR_X;
               e.valid  = 4'd0;
               e.data   = 4'd0;
               e.done   = 1'b1;
               e.perr   = (port >= np);
               e.addr   = port[1:0];
               e.parerr = (PAR_X == 1) ? bad_par : 1'b0;
               if (k == 0) qa.push_back(e); else qb.push_back(e);
            end
         end
      end
      for (int j = 0; j < bits.size(); j++) begin
         if (j > 0) @(negedge clk);
         ser_in = bits[j];
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_valid_a", bus_a.ser_out_valid, 4'd0);
      chk("reset_ser_out_a", bus_a.ser_out, 4'd0);
      chk("reset_port_addr_a", bus_a.port_addr, 2'd0);
      chk("reset_busy_a", bus_a.busy, 1'b0);
      chk("reset_done_a", bus_a.frame_done, 1'b0);
      chk("reset_port_err_b", bus_b.port_err, 1'b0);
      rst = 1'b1;
      idle(2);

      // Basic 3-bit payload to port 1.
      send_frame(1, 3, 15'b101, 1'b0, 1'b1);
      idle(3);
      chk("busy_after_frame_a", bus_a.busy, 1'b0);
      chk("busy_after_frame_b", bus_b.busy, 1'b0);

      // Zero-length frame to port 3 (invalid on the 3-port DUT).
      send_frame(3, 0, 15'd0, 1'b0, 1'b1);
      idle(2);
      chk("port_addr_len0_a", bus_a.port_addr, 2'd3);

      // Port 3 with payload: routed on DUT a, swallowed on DUT b.
      send_frame(3, 2, 15'b11, 1'b0, 1'b1);
      idle(2);

      // Back-to-back frames with no idle gap.
      send_frame(2, 1, 15'b1, 1'b0, 1'b1);
      send_frame(0, 1, 15'b0, 1'b0, 1'b1);
      idle(2);

      // Maximum length payload.
      send_frame(2, 15, 15'h5A3C, 1'b0, 1'b1);
      idle(2);

      // Reset pulse in the middle of a length-7 payload.
      mon_en = 1'b0;
      fork
         send_frame(1, 7, 15'h7F, 1'b0, 1'b0);
         begin
            repeat (10) @(negedge clk);
            #2;
            chk("busy_mid_data_a", bus_a.busy, 1'b1);
            chk("valid_mid_data_a", bus_a.ser_out_valid, 4'b0010);
            rst = 1'b0;
            #1;
            chk("abort_valid_a", bus_a.ser_out_valid, 4'd0);
            chk("abort_ser_out_a", bus_a.ser_out, 4'd0);
            chk("abort_busy_a", bus_a.busy, 1'b0);
            chk("abort_port_addr_a", bus_a.port_addr, 2'd0);
            chk("abort_valid_b", bus_b.ser_out_valid, 3'd0);
            @(negedge clk);
            rst = 1'b1;
         end
      join
      idle(3);
      chk("idle_after_abort_a", bus_a.busy, 1'b0);
      mon_en = 1'b1;
      send_frame(0, 2, 15'b10, 1'b0, 1'b1);
      idle(2);

      if (PAR_X == 1) begin
         send_frame(1, 1, 15'b1, 1'b0, 1'b1);
         send_frame(1, 1, 15'b1, 1'b1, 1'b1);
         send_frame(3, 0, 15'd0, 1'b1, 1'b1);
         idle(3);
      end

      idle(5);
      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
